// File: rtl/spdif_sample_feeder.sv
// Stereo PCM feeder for the S/PDIF transmitter: buffers {L,R} frames, serves
// per-channel pop requests with registered single-cycle acks, zero-fills on
// underrun or mute, and counts left-channel underruns.
module spdif_sample_feeder #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned UCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [47:0]           in_data_i,
  input  logic [1:0]            pop_i,
  output logic [1:0]            ack_o,
  output logic [47:0]           data_o,
  input  logic                  mute_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [UCNT_W-1:0]     underrun_cnt_o,
  input  logic                  clr_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [UCNT_W-1:0]     UCNT_ONE = {{(UCNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_L = 2'd1;
  localparam logic [1:0] ST_SERVE_R = 2'd2;

  logic [47:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [1:0]            state_q, state_d;
  logic [1:0]            pop_q;
  logic [1:0]            rise;
  logic                  pend_l_q, pend_l_d;
  logic                  pend_r_q, pend_r_d;
  logic                  pend_l_clr, pend_r_clr;
  logic [1:0]            ack_q, ack_d;
  logic [47:0]           data_q, data_d;
  logic [23:0]           hold_r_q, hold_r_d;
  logic [UCNT_W-1:0]     ucnt_q, ucnt_d;
  logic                  push;
  logic                  pop_fifo;
  logic                  fifo_empty;
  logic                  underrun;
  logic [47:0]           head;

  assign fifo_empty = (level_q == '0);
  assign in_ready_o = (level_q != FULL_LVL);
  assign push       = in_valid_i & in_ready_o;
  assign head       = mem_q[rd_ptr_q];
  assign rise       = pop_i & ~pop_q;

  assign ack_o          = ack_q;
  assign data_o         = data_q;
  assign level_o        = level_q;
  assign underrun_cnt_o = ucnt_q;

  // Serve sequencing: pick a pending channel, deliver it, build next outputs.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    data_d     = data_q;
    hold_r_d   = hold_r_q;
    pop_fifo   = 1'b0;
    underrun   = 1'b0;
    pend_l_clr = 1'b0;
    pend_r_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_l_q) begin
          state_d = ST_SERVE_L;
        end else if (pend_r_q) begin
          state_d = ST_SERVE_R;
        end
      end
      ST_SERVE_L: begin
        pop_fifo = ~fifo_empty;
        underrun = fifo_empty;
        if (mute_i || fifo_empty) begin
          data_d[47:24] = '0;
          hold_r_d      = '0;
        end else begin
          data_d[47:24] = head[47:24];
          hold_r_d      = head[23:0];
        end
        ack_d      = 2'b10;
        pend_l_clr = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_SERVE_R: begin
        data_d[23:0] = hold_r_q;
        ack_d        = 2'b01;
        pend_r_clr   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh rise on the serving edge is a new request, so set beats clear.
    pend_l_d = (pend_l_q & ~pend_l_clr) | rise[0];
    pend_r_d = (pend_r_q & ~pend_r_clr) | rise[1];
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push     ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_fifo ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop_fifo})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Saturating underrun counter; clear wins over an increment.
  always_comb begin
    ucnt_d = ucnt_q;
    if (clr_i) begin
      ucnt_d = '0;
    end else if (underrun && (ucnt_q != '1)) begin
      ucnt_d = ucnt_q + UCNT_ONE;
    end
  end

  // Frame storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      pop_q    <= '0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      ack_q    <= '0;
      data_q   <= '0;
      hold_r_q <= '0;
      ucnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      pop_q    <= pop_i;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      hold_r_q <= hold_r_d;
      ucnt_q   <= ucnt_d;
    end
  end

endmodule

// File: doc/spdif_sample_feeder.md
Name: spdif_sample_feeder

Overview:
- Sequences stereo PCM delivery into the S/PDIF transmitter (spdif_tx).
- Buffers 48-bit stereo frames from upstream: left in [47:24], right in [23:0].
- Answers the transmitter's per-channel pop requests with single-cycle ack pulses and stable sample data.
- Handles underrun and mute, and keeps status counters for the control path.

Parameters:
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 frames (default 8).
- UCNT_W, 16: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock, 98.304 MHz
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  upstream frame valid
- in_ready_o  out  1  FIFO not full
- in_data_i  in  48  upstream frame {L[23:0], R[23:0]}
- pop_i  in  2  transmitter requests; [0] = left sample wanted, [1] = right sample wanted; level signals
- ack_o  out  2  [1] = left data valid on data_o[47:24]; [0] = right data valid on data_o[23:0]; 1-cycle pulses
- data_o  out  48  sample data to the transmitter
- mute_i  in  1  force zero samples; FIFO still drains
- level_o  out  DEPTH_LOG2+1  frames currently stored
- underrun_cnt_o  out  UCNT_W  left requests served from an empty FIFO
- clr_i  in  1  synchronous clear of underrun_cnt_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - ack_o = 0, data_o = 0, level_o = 0, underrun_cnt_o = 0.
  - FIFO empty, in_ready_o = 1.
  - FSM = IDLE, pending flags cleared, pop edge registers = 0.
  - Reset mid-operation discards buffered frames and any in-flight ack.
- FIFO push:
  - A push occurs when in_valid_i & in_ready_o on a clk edge.
  - in_ready_o = (level_o != 2^DEPTH_LOG2).
  - Pointers wrap modulo depth.
  - A push and a pop in the same cycle leave level_o unchanged.
- Request capture:
  - pop_q <= pop_i each cycle; rise = pop_i & ~pop_q.
  - rise[0] sets pend_l; rise[1] sets pend_r.
  - A rise while the corresponding pend flag is already set is merged, not counted twice.
- FSM states:
  - IDLE:
    - If pend_l, go to SERVE_L.
    - Else if pend_r, go to SERVE_R.
    - Left has priority when both are pending.
  - SERVE_L (one cycle):
    - Pop one frame if the FIFO is non-empty.
    - data_o[47:24] <= mute_i ? 0 : frame L. If the FIFO is empty: 0, and underrun_cnt_o increments.
    - Latch R (same zero/mute rule) into hold_r.
    - ack_o[1] = 1 for exactly this cycle (registered).
    - Clear pend_l, return to IDLE.
  - SERVE_R (one cycle):
    - data_o[23:0] <= hold_r; ack_o[0] = 1 for one cycle.
    - Clear pend_r, return to IDLE.
    - A right request with no preceding left serve returns the current hold_r (0 after reset).
- Latency: with the FSM idle, ack goes high 2 clk after the edge that first samples the pop_i bit high.
- data_o halves are held stable from their ack until the next ack of the same half.
- ack_o[1] and ack_o[0] are never high in the same cycle.
- Consecutive acks are at least 2 cycles apart (SERVE, then IDLE).
- underrun_cnt_o saturates at all-ones. clr_i has priority over an increment in the same cycle.
- mute_i is sampled in SERVE_L only. A right half already latched follows the mute state at its left serve.

Test Plan:
- Reset: assert rst_n=0 mid-serve → ack_o, data_o, level_o and underrun_cnt_o all 0 immediately, without a clock edge; in_ready_o=1.
- Normal flow: push frames {L=n, R=24'habcdef} for n=0..9 (FIFO full after 8, in_ready_o=0); pulse pop_i[0] then pop_i[1] repeatedly → left acks carry 0,1,2…9 in order; every right ack carries abcdef; each ack is 2 clk after its pop rise.
- Underrun: FIFO empty, 3 left requests → data_o[47:24]=0, data_o[23:0]=0 on the following right ack, underrun_cnt_o=3; then pulse clr_i → 0.
- Simultaneous: pop_i rises 2'b11 in one cycle → ack_o[1] in cycle k+2, ack_o[0] in cycle k+4; never both at once.
- Mute: frame {L=24'h123456, R=24'h654321} with mute_i=1 → both halves delivered as 0; level_o decrements by 1.
- Wrap and saturation: push/pop 300 frames with the level hovering at 7–8 → no loss or reorder across the pointer wrap; with UCNT_W=4, 20 underruns → underrun_cnt_o = 4'hf.
